hv_encoder_multi: RTL

HV_ENCODER_MULTI -- requirements
Module: hv_encoder_multi

---
 rtl/hv_encoder_pkg.sv | 44 ++++
 rtl/hv_encoder_multi_iter_ctrl.sv | 98 +++++++++
 rtl/hv_encoder_multi.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hv_encoder_pkg.sv
// ---------------------------------------------------------------------------
// hv_encoder_pkg
// Shared encodings for the multi-bundler hypervector encoder:
//   - source-select codes used by the ALU operand, register-write and
//     query-push multiplexers (bundler k is selected by SrcBund0 + k)
//   - ALU operation and bundler-input enumerations
//   - iteration FSM state enumeration
//   - select/iteration widths for the default configuration
// ---------------------------------------------------------------------------
package hv_encoder_pkg;

    localparam int DefNumBund = 4;
    localparam int DefMaxIter = 15;

    // Widths of the source selects and of the ALU repeat count.
    localparam int SrcW  = $clog2(2 + DefNumBund);
    localparam int IterW = $clog2(DefMaxIter + 1);

    // Source-select codes. For ALU operands code 0 is the item-memory port
    // instead of the ALU output.
    localparam logic [SrcW-1:0] SrcAlu   = SrcW'(0);
    localparam logic [SrcW-1:0] SrcReg   = SrcW'(1);
    localparam logic [SrcW-1:0] SrcBund0 = SrcW'(2);

    typedef enum logic [1:0] {
        AluXor  = 2'd0,
        AluAnd  = 2'd1,
        AluOr   = 2'd2,
        AluPerm = 2'd3   // circular left rotate of operand A
    } alu_op_e;

    typedef enum logic [1:0] {
        BundSrcAlu  = 2'd0,
        BundSrcImA  = 2'd1,
        BundSrcRegA = 2'd2,
        BundSrcZero = 2'd3
    } bund_src_e;

    typedef enum logic {
        StIdle = 1'b0,
        StIter = 1'b1
    } iter_state_e;

endpackage

// File: rtl/hv_encoder_multi_iter_ctrl.sv
// ---------------------------------------------------------------------------
// hv_iter_ctrl
// Instruction sequencing for hv_encoder_multi: decides when an instruction
// retires and when the iteration register captures the ALU result.
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   stall_i         freezes the FSM and the pass counter
//   instr_valid_i   instruction offered
//   iter_i          requested extra ALU passes (saturated to MaxIter)
//   push_block_i    query push would overflow the FIFO this cycle
//   retire_o        instruction retires this cycle (drives instr_ready_o)
//   iter_load_o     iteration register captures the ALU output
//   iter_sel_o      ALU operand A comes from the iteration register
//   busy_o          high exactly while in the ITER state
// ---------------------------------------------------------------------------
module hv_iter_ctrl
    import hv_encoder_pkg::*;
#(
    parameter int MaxIter = 15,
    parameter int IterW   = $clog2(MaxIter + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             stall_i,
    input  logic             instr_valid_i,
    input  logic [IterW-1:0] iter_i,
    input  logic             push_block_i,
    output logic             retire_o,
    output logic             iter_load_o,
    output logic             iter_sel_o,
    output logic             busy_o
);

    iter_state_e      state_q, state_d;
    logic [IterW-1:0] cnt_q, cnt_d;
    logic [IterW-1:0] iter_sat;
    logic             retire;

    always_comb begin
        iter_sat = iter_i;
        if (int'(iter_i) > MaxIter) begin
            iter_sat = IterW'(MaxIter);
        end
    end

    // cnt_q holds the number of passes still to run, the current one included.
    // The final pass is repeated while the query push is blocked; since the
    // iteration register does not move, the result stays the same.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        retire      = 1'b0;
        iter_load_o = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (instr_valid_i && !stall_i) begin
                    if (iter_sat == '0) begin
                        retire = !push_block_i;
                    end else begin
                        iter_load_o = 1'b1;
                        cnt_d       = iter_sat;
                        state_d     = StIter;
                    end
                end
            end
            StIter: begin
                if (!stall_i) begin
                    if (cnt_q == IterW'(1)) begin
                        if (!push_block_i) begin
                            retire  = 1'b1;
                            state_d = StIdle;
                        end
                    end else begin
                        iter_load_o = 1'b1;
                        cnt_d       = cnt_q - IterW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The handshake must read low while reset is asserted even if an
    // instruction is already being offered.
    assign retire_o   = retire & rst_ni;
    assign iter_sel_o = (state_q == StIter);
    assign busy_o     = (state_q == StIter);

endmodule

// File: rtl/hv_encoder_multi.sv
// ---------------------------------------------------------------------------
// hv_encoder_multi
// Hypervector encoder datapath: a two-read/one-write register file, a
// bitwise/permute ALU with optional repeated passes, NumBund saturating
// bundlers with binarised outputs, and a first-word-fall-through query FIFO.
// Ports:
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   global_stall_i                 freezes all state (FIFO pop still allowed)
//   im_rd_a_i, im_rd_b_i           item-memory operands
//   instr_valid_i / instr_ready_o  instruction offer / retire strobe
//   alu_src_a_i, alu_src_b_i       ALU operand selects
//   alu_ops_i, alu_shift_amt_i     ALU operation and rotate amount
//   alu_iter_i                     extra ALU passes
//   bund_src_i, bund_en_i,
//   bund_clr_i                     bundler input select, accumulate, clear
//   reg_src_i, reg_rd_addr_a_i,
//   reg_rd_addr_b_i, reg_wr_addr_i,
//   reg_wr_en_i                    register file control
//   qhv_wen_i, qhv_src_i           query push and its source
//   qhv_o, qhv_valid_o, qhv_ready_i query FIFO head, non-empty, pop
//   busy_o                         ALU iteration in progress
// ---------------------------------------------------------------------------
module hv_encoder_multi
    import hv_encoder_pkg::*;
#(
    parameter int HVDimension    = 512,
    parameter int NumBund        = 4,
    parameter int BundCountWidth = 8,
    parameter int RegNum         = 8,
    parameter int ALUMaxShiftAmt = 128,
    parameter int MaxIter        = 15,
    parameter int QhvDepth       = 2
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               global_stall_i,
    input  logic [HVDimension-1:0]             im_rd_a_i,
    input  logic [HVDimension-1:0]             im_rd_b_i,
    input  logic                               instr_valid_i,
    output logic                               instr_ready_o,
    input  logic [$clog2(2+NumBund)-1:0]       alu_src_a_i,
    input  logic [$clog2(2+NumBund)-1:0]       alu_src_b_i,
    input  logic [1:0]                         alu_ops_i,
    input  logic [$clog2(ALUMaxShiftAmt)-1:0]  alu_shift_amt_i,
    input  logic [$clog2(MaxIter+1)-1:0]       alu_iter_i,
    input  logic [1:0]                         bund_src_i,
    input  logic [NumBund-1:0]                 bund_en_i,
    input  logic [NumBund-1:0]                 bund_clr_i,
    input  logic [$clog2(2+NumBund)-1:0]       reg_src_i,
    input  logic [$clog2(RegNum)-1:0]          reg_rd_addr_a_i,
    input  logic [$clog2(RegNum)-1:0]          reg_rd_addr_b_i,
    input  logic [$clog2(RegNum)-1:0]          reg_wr_addr_i,
    input  logic                               reg_wr_en_i,
    input  logic                               qhv_wen_i,
    input  logic [$clog2(2+NumBund)-1:0]       qhv_src_i,
    output logic [HVDimension-1:0]             qhv_o,
    output logic                               qhv_valid_o,
    input  logic                               qhv_ready_i,
    output logic                               busy_o
);

    localparam int SelW   = $clog2(2 + NumBund);
    localparam int ShiftW = $clog2(ALUMaxShiftAmt);
    localparam int ItW    = $clog2(MaxIter + 1);
    localparam int PtrW   = $clog2(QhvDepth);

    localparam logic signed [BundCountWidth-1:0] CntMax = {1'b0, {(BundCountWidth-1){1'b1}}};
    localparam logic signed [BundCountWidth-1:0] CntMin = {1'b1, {(BundCountWidth-1){1'b0}}};
    localparam logic signed [BundCountWidth-1:0] CntOne = {{(BundCountWidth-1){1'b0}}, 1'b1};

    // Saturating +1 / -1 step of one bundler counter.
    function automatic logic signed [BundCountWidth-1:0] bund_step(
        input logic signed [BundCountWidth-1:0] cnt,
        input logic                             bit_in
    );
        logic signed [BundCountWidth-1:0] nxt;
        if (bit_in) begin
            nxt = (cnt == CntMax) ? cnt : cnt + CntOne;
        end else begin
            nxt = (cnt == CntMin) ? cnt : cnt - CntOne;
        end
        return nxt;
    endfunction

    // Shared source decode: 0 -> src0, 1 -> src1, 2+k -> bundler k, else zero.
    function automatic logic [HVDimension-1:0] pick_src(
        input logic [SelW-1:0]                      sel,
        input logic [HVDimension-1:0]               src0,
        input logic [HVDimension-1:0]               src1,
        input logic [NumBund-1:0][HVDimension-1:0]  bund
    );
        logic [HVDimension-1:0] res;
        res = '0;
        if (sel == SelW'(0)) begin
            res = src0;
        end else if (sel == SelW'(1)) begin
            res = src1;
        end else begin
            for (int k = 0; k < NumBund; k++) begin
                if (sel == SelW'(2 + k)) begin
                    res = bund[k];
                end
            end
        end
        return res;
    endfunction

    function automatic logic [HVDimension-1:0] rotl(
        input logic [HVDimension-1:0] v,
        input logic [ShiftW-1:0]      sh
    );
        return (v << sh) | (v >> (HVDimension - int'(sh)));
    endfunction

    logic                               retire;
    logic                               iter_load;
    logic                               iter_sel;
    logic                               push_block;
    logic                               fifo_push;
    logic                               fifo_pop;
    logic                               fifo_full;

    logic [HVDimension-1:0]             regs [RegNum];
    logic [HVDimension-1:0]             reg_rd_a;
    logic [HVDimension-1:0]             reg_rd_b;
    logic [HVDimension-1:0]             iter_q;
    logic [HVDimension-1:0]             alu_a;
    logic [HVDimension-1:0]             alu_b;
    logic [HVDimension-1:0]             alu_out;
    logic [HVDimension-1:0]             reg_wdata;
    logic [HVDimension-1:0]             qhv_wdata;
    logic [HVDimension-1:0]             bund_in;
    logic [NumBund-1:0][HVDimension-1:0] bund_bin;
    logic signed [BundCountWidth-1:0]   bund_cnt [NumBund][HVDimension];

    logic [HVDimension-1:0]             fifo_mem [QhvDepth];
    logic [PtrW-1:0]                    wr_ptr_q;
    logic [PtrW-1:0]                    rd_ptr_q;
    logic [PtrW:0]                      fifo_cnt_q;

    hv_iter_ctrl #(
        .MaxIter (MaxIter),
        .IterW   (ItW)
    ) u_iter_ctrl (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .stall_i       (global_stall_i),
        .instr_valid_i (instr_valid_i),
        .iter_i        (alu_iter_i),
        .push_block_i  (push_block),
        .retire_o      (retire),
        .iter_load_o   (iter_load),
        .iter_sel_o    (iter_sel),
        .busy_o        (busy_o)
    );

    assign instr_ready_o = retire;

    assign reg_rd_a = regs[reg_rd_addr_a_i];
    assign reg_rd_b = regs[reg_rd_addr_b_i];

    // A bundler bit is set only when its counter is strictly positive, so a
    // cleared bundler reads as all-zero.
    always_comb begin
        bund_bin = '0;
        for (int k = 0; k < NumBund; k++) begin
            for (int i = 0; i < HVDimension; i++) begin
                bund_bin[k][i] = !bund_cnt[k][i][BundCountWidth-1] && (bund_cnt[k][i] != '0);
            end
        end
    end

    // During extra passes operand A is the previous pass result; op, B and
    // shift keep coming from the held instruction.
    always_comb begin
        alu_a = pick_src(alu_src_a_i, im_rd_a_i, reg_rd_a, bund_bin);
        if (iter_sel) begin
            alu_a = iter_q;
        end
        alu_b = pick_src(alu_src_b_i, im_rd_b_i, reg_rd_b, bund_bin);
    end

    always_comb begin
        alu_out = '0;
        unique case (alu_op_e'(alu_ops_i))
            AluXor:  alu_out = alu_a ^ alu_b;
            AluAnd:  alu_out = alu_a & alu_b;
            AluOr:   alu_out = alu_a | alu_b;
            AluPerm: alu_out = rotl(alu_a, alu_shift_amt_i);
            default: alu_out = '0;
        endcase
    end

    assign reg_wdata = pick_src(reg_src_i, alu_out, reg_rd_a, bund_bin);
    assign qhv_wdata = pick_src(qhv_src_i, alu_out, reg_rd_a, bund_bin);

    always_comb begin
        bund_in = '0;
        unique case (bund_src_e'(bund_src_i))
            BundSrcAlu:  bund_in = alu_out;
            BundSrcImA:  bund_in = im_rd_a_i;
            BundSrcRegA: bund_in = reg_rd_a;
            BundSrcZero: bund_in = '0;
            default:     bund_in = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            iter_q <= '0;
        end else if (iter_load) begin
            iter_q <= alu_out;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int r = 0; r < RegNum; r++) begin
                regs[r] <= '0;
            end
        end else if (retire && reg_wr_en_i) begin
            regs[reg_wr_addr_i] <= reg_wdata;
        end
    end

    // Clear wins over accumulate on the same bundler.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < NumBund; k++) begin
                for (int i = 0; i < HVDimension; i++) begin
                    bund_cnt[k][i] <= '0;
                end
            end
        end else if (retire) begin
            for (int k = 0; k < NumBund; k++) begin
                for (int i = 0; i < HVDimension; i++) begin
                    if (bund_clr_i[k]) begin
                        bund_cnt[k][i] <= '0;
                    end else if (bund_en_i[k]) begin
                        bund_cnt[k][i] <= bund_step(bund_cnt[k][i], bund_in[i]);
                    end
                end
            end
        end
    end

    // Query FIFO. A pop in the same cycle frees the slot the push needs, and
    // pops are honoured even under global stall.
    assign qhv_valid_o = (fifo_cnt_q != '0);
    assign fifo_full   = (fifo_cnt_q == (PtrW+1)'(QhvDepth));
    assign fifo_pop    = qhv_valid_o && qhv_ready_i;
    assign push_block  = qhv_wen_i && fifo_full && !fifo_pop;
    assign fifo_push   = retire && qhv_wen_i;
    assign qhv_o       = qhv_valid_o ? fifo_mem[rd_ptr_q] : '0;

    always_ff @(posedge clk_i) begin
        if (fifo_push) begin
            fifo_mem[wr_ptr_q] <= qhv_wdata;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (fifo_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (fifo_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            unique case ({fifo_push, fifo_pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + 1'b1;
                2'b01:   fifo_cnt_q <= fifo_cnt_q - 1'b1;
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

endmodule
